branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 173 +++++++++++++++++
 tb/tb_branch_resolve.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// branch_resolve -- branch resolution stage for a small in-order pipeline.
//
// Holds two registered slots (ID, EX) fed from the fetch stage. The EX slot
// is resolved combinationally: control-flow instructions are decoded, the
// actual outcome and target computed, and compared with the fetch-time
// prediction. A mispredict raises redirect and squashes both younger slots.
// Conditional branches additionally emit a predictor training strobe.
//
// Optional feature: define BRANCH_STATS_EN to add the branch / mispredict
// statistics counters and their output ports.
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   stall               - hold both slots, suppress redirect/update/counters
//   if_valid, if_instr, if_pc, if_pred_taken, if_pred_pc
//                       - fetch-stage instruction and its prediction
//   ex_rs1, ex_rs2      - register operands aligned with the EX slot
//   redirect, redirect_pc          - flush + refetch request, correct next PC
//   update_en, actual_taken, update_pc - predictor training outputs
//   stat_branches, stat_mispredicts   - counters (BRANCH_STATS_EN only)

module branch_resolve #(
    parameter int CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        if_pred_taken,
    input  logic [31:0] if_pred_pc,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        update_en,
    output logic        actual_taken,
    output logic [31:0] update_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stat_branches,
    output logic [CNT_WIDTH-1:0] stat_mispredicts
`endif
);

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_pc;
    } slot_t;

    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    slot_t id_slot, ex_slot;

    // ------------------------------------------------------------------
    // Slot pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_slot <= '0;
            ex_slot <= '0;
        end else if (!stall) begin
            if (redirect) begin
                // Both younger instructions are on the wrong path: the one
                // arriving from IF lands in ID already invalidated, and EX
                // receives a bubble instead of the old ID contents.
                id_slot <= '{valid: 1'b0, instr: if_instr, pc: if_pc,
                             pred_taken: if_pred_taken, pred_pc: if_pred_pc};
                ex_slot <= '0;
            end else begin
                ex_slot <= id_slot;
                id_slot <= '{valid: if_valid, instr: if_instr, pc: if_pc,
                             pred_taken: if_pred_taken, pred_pc: if_pred_pc};
            end
        end
    end

    // ------------------------------------------------------------------
    // EX resolution
    // ------------------------------------------------------------------
    logic [4:0]  op5;
    logic [2:0]  funct3;
    logic        is_jal, is_branch, is_jalr;
    logic [31:0] imm_j, imm_b, imm_i;
    logic [31:0] pc_plus4;
    logic        cond;
    logic        taken;
    logic [31:0] target;
    logic        mispredict;

    assign op5       = ex_slot.instr[6:2];
    assign funct3    = ex_slot.instr[14:12];
    assign is_jal    = (op5 == OP_JAL);
    assign is_branch = (op5 == OP_BRANCH);
    assign is_jalr   = (op5 == OP_JALR);

    assign imm_j = {{12{ex_slot.instr[31]}}, ex_slot.instr[19:12], ex_slot.instr[20],
                    ex_slot.instr[30:21], 1'b0};
    assign imm_b = {{20{ex_slot.instr[31]}}, ex_slot.instr[7], ex_slot.instr[30:25],
                    ex_slot.instr[11:8], 1'b0};
    assign imm_i = {{20{ex_slot.instr[31]}}, ex_slot.instr[31:20]};

    assign pc_plus4 = ex_slot.pc + 32'd4;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = (ex_rs1 == ex_rs2);
            3'b001:  cond = (ex_rs1 != ex_rs2);
            3'b100:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  cond = (ex_rs1 <  ex_rs2);
            3'b111:  cond = (ex_rs1 >= ex_rs2);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        taken  = 1'b0;
        target = 32'd0;
        if (is_jal) begin
            taken  = 1'b1;
            target = ex_slot.pc + imm_j;
        end else if (is_branch) begin
            taken  = cond;
            target = ex_slot.pc + imm_b;
        end else if (is_jalr) begin
            taken  = 1'b1;
            target = (ex_rs1 + imm_i) & 32'hFFFF_FFFE;
        end
    end

    // JALR targets are never trusted from fetch, so it always refetches.
    // A non-control instruction predicted taken falls out of the second term.
    assign mispredict = is_jalr
                      || (taken != ex_slot.pred_taken)
                      || (taken && (ex_slot.pred_pc != target));

    assign redirect     = ex_slot.valid && !stall && mispredict;
    assign redirect_pc  = ex_slot.valid ? (taken ? target : pc_plus4) : 32'd0;
    assign actual_taken = ex_slot.valid && taken;
    assign update_en    = ex_slot.valid && !stall && is_branch;
    assign update_pc    = update_en ? ex_slot.pc : 32'd0;

    // Low opcode bits do not participate in classification.
    logic unused_bits;
    assign unused_bits = &{1'b0, ex_slot.instr[1:0]};

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (update_en) stat_branches    <= stat_branches + CNT_WIDTH'(1);
            if (redirect)  stat_mispredicts <= stat_mispredicts + CNT_WIDTH'(1);
        end
    end
`else
    logic [CNT_WIDTH-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve -- directed + randomized bench for branch_resolve.
// Instructions are built from (kind, funct3, immediate) by an encoder; the
// reference model works from those fields and a two-entry in-flight queue.
// Compile with +define+BRANCH_STATS_EN to also check the counters.

module tb_branch_resolve;

    localparam int K_OTHER = 0;
    localparam int K_BR    = 1;
    localparam int K_JAL   = 2;
    localparam int K_JALR  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_pc;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        update_en;
    logic        actual_taken;
    logic [31:0] update_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_resolve #(.CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_pc(if_pred_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .update_en(update_en), .actual_taken(actual_taken), .update_pc(update_pc)
`ifdef BRANCH_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    typedef struct {
        bit          v;
        int          kind;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        bit          pt;
        logic [31:0] pp;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic        r;
        logic [31:0] rpc;
        logic        at;
        logic        ue;
        logic [31:0] upc;
    } exp_t;

    int n_chk  = 0;
    int n_fail = 0;

    ent_t id_m, ex_m, cur_f;
    exp_t cur;
    bit   cur_st;
    logic [31:0] m_br, m_mis;

    function automatic ent_t bub();
        ent_t e;
        e.v = 0; e.kind = K_OTHER; e.f3 = 3'd0; e.imm = 32'd0; e.pc = 32'd0;
        e.rs1 = 32'd0; e.rs2 = 32'd0; e.pt = 0; e.pp = 32'd0; e.instr = 32'd0;
        return e;
    endfunction

    // Encode an instruction from its fields (inverse of the hardware decoder).
    function automatic ent_t mk(int kind, logic [2:0] f3, logic [31:0] imm,
                                logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2,
                                bit pt, logic [31:0] pp);
        ent_t e;
        e.v = 1; e.kind = kind; e.f3 = f3; e.imm = imm; e.pc = pc;
        e.rs1 = rs1; e.rs2 = rs2; e.pt = pt; e.pp = pp;
        case (kind)
            K_BR:    e.instr = {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
            K_JAL:   e.instr = {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
            K_JALR:  e.instr = {imm[11:0], 5'd1, 3'b000, 5'd1, 7'b1100111};
            default: e.instr = {imm[11:0], 5'd1, f3, 5'd1, 7'b0010011};
        endcase
        return e;
    endfunction

    function automatic bit br_cond(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] true_target(ent_t e);
        if (e.kind == K_JALR) return (e.rs1 + e.imm) & 32'hFFFF_FFFE;
        return e.pc + e.imm;
    endfunction

    function automatic exp_t model(ent_t e, bit st);
        exp_t x;
        bit tk;
        bit mis;
        logic [31:0] tgt;
        x.r = 0; x.rpc = 32'd0; x.at = 0; x.ue = 0; x.upc = 32'd0;
        if (!e.v) return x;
        tgt = true_target(e);
        case (e.kind)
            K_BR:    tk = br_cond(e.f3, e.rs1, e.rs2);
            K_JAL:   tk = 1;
            K_JALR:  tk = 1;
            default: tk = 0;
        endcase
        mis   = (e.kind == K_JALR) || (tk != e.pt) || (tk && e.pp != tgt);
        x.at  = tk;
        x.rpc = tk ? tgt : e.pc + 32'd4;
        x.r   = mis && !st;
        x.ue  = (e.kind == K_BR) && !st;
        x.upc = x.ue ? e.pc : 32'd0;
        return x;
    endfunction

    function automatic ent_t rnd();
        ent_t e;
        int kind;
        logic [31:0] imm, pc, a, b, pp;
        logic [12:0] t13;
        logic [20:0] t21;
        logic [11:0] t12;
        bit pt;
        kind = int'($urandom_range(0, 3));
        t13 = 13'($urandom); t13[0] = 1'b0;
        t21 = 21'($urandom); t21[0] = 1'b0;
        t12 = 12'($urandom);
        case (kind)
            K_BR:    imm = {{19{t13[12]}}, t13};
            K_JAL:   imm = {{11{t21[20]}}, t21};
            default: imm = {{20{t12[11]}}, t12};
        endcase
        pc = $urandom & 32'hFFFF_FFFC;
        a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
        b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
        pt = 1'($urandom_range(0, 1));
        e  = mk(kind, 3'($urandom_range(0, 7)), imm, pc, a, b, pt, 32'd0);
        pp = ($urandom_range(0, 1) == 1) ? true_target(e) : ($urandom & 32'hFFFF_FFFC);
        e.pp = pp;
        e.instr = mk(kind, e.f3, imm, pc, a, b, pt, pp).instr;
        e.v = ($urandom_range(0, 7) != 0);
        return e;
    endfunction

    task automatic chk1(string tag, logic got, logic exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk32(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic outputs_zero(string tag);
        chk1({tag, "_redirect"}, redirect, 1'b0);
        chk32({tag, "_redirect_pc"}, redirect_pc, 32'd0);
        chk1({tag, "_update_en"}, update_en, 1'b0);
        chk1({tag, "_actual_taken"}, actual_taken, 1'b0);
        chk32({tag, "_update_pc"}, update_pc, 32'd0);
`ifdef BRANCH_STATS_EN
        chk32({tag, "_stat_branches"}, stat_branches, 32'd0);
        chk32({tag, "_stat_mispredicts"}, stat_mispredicts, 32'd0);
`endif
    endtask

    // Drive one cycle's inputs and check outputs against the model.
    task automatic cyc(input ent_t f, input bit st);
        if_valid = f.v; if_instr = f.instr; if_pc = f.pc;
        if_pred_taken = f.pt; if_pred_pc = f.pp;
        stall = st; ex_rs1 = ex_m.rs1; ex_rs2 = ex_m.rs2;
        cur = model(ex_m, st); cur_f = f; cur_st = st;
        #1;
        chk1("redirect", redirect, cur.r);
        chk32("redirect_pc", redirect_pc, cur.rpc);
        chk1("actual_taken", actual_taken, cur.at);
        chk1("update_en", update_en, cur.ue);
        chk32("update_pc", update_pc, cur.upc);
`ifdef BRANCH_STATS_EN
        chk32("stat_branches", stat_branches, m_br);
        chk32("stat_mispredicts", stat_mispredicts, m_mis);
`endif
    endtask

    // Clock edge: advance the in-flight queue the way the spec describes.
    task automatic tick();
        @(posedge clk);
        if (!cur_st) begin
            if (cur.ue) m_br++;
            if (cur.r) begin
                m_mis++;
                id_m = cur_f; id_m.v = 0;
                ex_m = bub();
            end else begin
                ex_m = id_m;
                id_m = cur_f;
            end
        end
        #1;
    endtask

    initial begin
        ent_t e, y1, y2;
`ifdef BRANCH_STATS_EN
        logic [31:0] mis_before;
`endif
        reset = 1'b1; stall = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
        if_pred_taken = 1'b0; if_pred_pc = 32'd0; ex_rs1 = 32'd0; ex_rs2 = 32'd0;
        id_m = bub(); ex_m = bub(); m_br = 32'd0; m_mis = 32'd0;
        cur_st = 0; cur_f = bub(); cur = model(bub(), 0);
        #2;
        outputs_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // BEQ taken, predicted not-taken
        cyc(mk(K_BR, 3'd0, 32'd16, 32'h100, 32'd5, 32'd5, 0, 32'd0), 0); tick();
        cyc(bub(), 0); tick();
        cyc(bub(), 0);
        chk1("beq_redirect", redirect, 1'b1);
        chk32("beq_redirect_pc", redirect_pc, 32'h110);
        chk1("beq_update_en", update_en, 1'b1);
        chk1("beq_taken", actual_taken, 1'b1);
        tick();
        cyc(bub(), 0); tick();
        cyc(bub(), 0); tick();

        // BLT signed, correctly predicted
        cyc(mk(K_BR, 3'd4, 32'h20, 32'h200, 32'hFFFF_FFFF, 32'd1, 1, 32'h220), 0); tick();
        cyc(bub(), 0); tick();
        cyc(bub(), 0);
        chk1("blt_redirect", redirect, 1'b0);
        chk1("blt_update_en", update_en, 1'b1);
        chk1("blt_taken", actual_taken, 1'b1);
        chk32("blt_update_pc", update_pc, 32'h200);
        tick();

        // BLTU with same operands: not taken
        cyc(mk(K_BR, 3'd6, 32'h20, 32'h200, 32'hFFFF_FFFF, 32'd1, 1, 32'h220), 0); tick();
        cyc(bub(), 0); tick();
        cyc(bub(), 0);
        chk1("bltu_redirect", redirect, 1'b1);
        chk32("bltu_redirect_pc", redirect_pc, 32'h204);
        chk1("bltu_taken", actual_taken, 1'b0);
        tick();

        // JALR kills the two younger branches
        y1 = mk(K_BR, 3'd0, 32'd8, 32'h304, 32'd7, 32'd7, 0, 32'd0);
        y2 = mk(K_BR, 3'd1, 32'd8, 32'h308, 32'd1, 32'd2, 0, 32'd0);
        cyc(mk(K_JALR, 3'd0, 32'd4, 32'h300, 32'h1001, 32'd0, 0, 32'd0), 0); tick();
        cyc(y1, 0); tick();
        cyc(y2, 0);
        chk1("jalr_redirect", redirect, 1'b1);
        chk32("jalr_redirect_pc", redirect_pc, 32'h1004);
        chk1("jalr_update_en", update_en, 1'b0);
        tick();
        cyc(bub(), 0);
        chk1("killed1_update_en", update_en, 1'b0);
        chk1("killed1_redirect", redirect, 1'b0);
        tick();
        cyc(bub(), 0);
        chk1("killed2_update_en", update_en, 1'b0);
        chk1("killed2_redirect", redirect, 1'b0);
        tick();

        // Mispredicted BNE held by stall for three cycles
        cyc(mk(K_BR, 3'd1, 32'h40, 32'h400, 32'd1, 32'd2, 0, 32'd0), 0); tick();
        cyc(bub(), 0); tick();
`ifdef BRANCH_STATS_EN
        mis_before = m_mis;
`endif
        for (int i = 0; i < 3; i++) begin
            cyc(mk(K_OTHER, 3'd0, 32'd0, 32'h500, 32'd0, 32'd0, 1, 32'd0), 1);
            chk1("stall_redirect", redirect, 1'b0);
            chk1("stall_update_en", update_en, 1'b0);
            tick();
        end
        cyc(bub(), 0);
        chk1("release_redirect", redirect, 1'b1);
        chk32("release_redirect_pc", redirect_pc, 32'h440);
        tick();
        cyc(bub(), 0);
        chk1("release_once", redirect, 1'b0);
`ifdef BRANCH_STATS_EN
        chk32("stall_mis_delta", stat_mispredicts - mis_before, 32'd1);
`endif
        tick();

        // Reset while a branch sits in EX
        cyc(mk(K_BR, 3'd0, 32'd16, 32'h600, 32'd3, 32'd3, 0, 32'd0), 0); tick();
        cyc(bub(), 0); tick();
        cyc(bub(), 0);
        reset = 1'b1;
        #1;
        outputs_zero("midreset");
        id_m = bub(); ex_m = bub(); m_br = 32'd0; m_mis = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(bub(), 0);
            chk1("post_reset_update_en", update_en, 1'b0);
            tick();
        end

        // Randomized traffic with occasional stalls
        for (int i = 0; i < 400; i++) begin
            e = rnd();
            cyc(e, ($urandom_range(0, 4) == 0));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
